// File: rtl/leds_pattern_gen.sv
// Parametrised LED pattern engine: swing, rotate, fill and blink patterns paced by a prescaler.
// Optional PWM dimming is built in when LEDS_PWM_DIM_EN is defined (adds the dim input).
module leds_pattern_gen #(
  parameter int unsigned NUM_LEDS      = 8,
  parameter int unsigned BAR_WIDTH     = 2,
  parameter int unsigned COUNTER_WIDTH = 24,
  parameter bit          ACTIVE_LOW    = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [COUNTER_WIDTH-1:0] period,
`ifdef LEDS_PWM_DIM_EN
  input  logic [3:0]               dim,
`endif
  output logic                     step,
  output logic [NUM_LEDS-1:0]      data
);

  localparam int unsigned PosW = $clog2(NUM_LEDS);
  localparam int unsigned LvlW = $clog2(NUM_LEDS + 1);
  localparam logic [PosW-1:0] PosMax = PosW'(NUM_LEDS - BAR_WIDTH);
  localparam logic [LvlW-1:0] LvlMax = LvlW'(NUM_LEDS);
  localparam logic [NUM_LEDS-1:0] BarMask = NUM_LEDS'((64'd1 << BAR_WIDTH) - 64'd1);
  localparam logic [NUM_LEDS-1:0] BarInit = BarMask << (NUM_LEDS - BAR_WIDTH);
  localparam logic [NUM_LEDS-1:0] Pol = {NUM_LEDS{ACTIVE_LOW}};

  typedef enum logic [1:0] {ModeSwing, ModeRotate, ModeFill, ModeBlink} mode_e;

  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  mode_e                    active_mode_q, active_mode_d;
  logic [PosW-1:0]          pos_q, pos_d;
  logic                     dir_up_q, dir_up_d;
  logic [LvlW-1:0]          level_q, level_d;
  logic                     level_up_q, level_up_d;
  logic                     blink_q, blink_d;
  logic [NUM_LEDS-1:0]      pat_q, pat_d;
  logic                     step_q, step_d;
  logic [NUM_LEDS-1:0]      data_q, data_d;
  logic [NUM_LEDS-1:0]      dim_mask;
  mode_e                    mode_req;

  function automatic logic [NUM_LEDS-1:0] thermo(input logic [LvlW-1:0] lvl);
    logic [NUM_LEDS-1:0] t;
    for (int unsigned i = 0; i < NUM_LEDS; i++) t[i] = (i < 32'(lvl));
    return t;
  endfunction

  function automatic logic [NUM_LEDS-1:0] init_pattern(input mode_e m);
    logic [NUM_LEDS-1:0] p;
    unique case (m)
      ModeSwing, ModeRotate: p = BarInit;
      ModeFill:              p = '0;
      ModeBlink:             p = '1;
    endcase
    return p;
  endfunction

`ifdef LEDS_PWM_DIM_EN
  logic [3:0] pwm_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt_q <= 4'd0;
    else        pwm_cnt_q <= pwm_cnt_q + 4'd1;
  end

  assign dim_mask = {NUM_LEDS{pwm_cnt_q <= dim}};
`else
  assign dim_mask = '1;
`endif

  assign mode_req = mode_e'(mode);

  always_comb begin
    counter_d     = counter_q;
    active_mode_d = active_mode_q;
    pos_d         = pos_q;
    dir_up_d      = dir_up_q;
    level_d       = level_q;
    level_up_d    = level_up_q;
    blink_d       = blink_q;
    pat_d         = pat_q;
    step_d        = 1'b0;
    // A mode change takes priority over any tick and loads that mode's init pattern.
    if (mode_req != active_mode_q) begin
      active_mode_d = mode_req;
      counter_d     = '0;
      pos_d         = PosMax;
      dir_up_d      = 1'b0;
      level_d       = '0;
      level_up_d    = 1'b1;
      blink_d       = 1'b1;
      pat_d         = init_pattern(mode_req);
    end else if (enable) begin
      if (counter_q < period) begin
        counter_d = counter_q + 1'b1;
      end else begin
        counter_d = '0;
        step_d    = 1'b1;
        unique case (active_mode_q)
          ModeSwing: begin
            if (pos_q > PosMax) begin
              pos_d    = PosMax;
              dir_up_d = 1'b0;
            end else if (dir_up_q) begin
              if (pos_q == PosMax) begin
                dir_up_d = 1'b0;
                pos_d    = PosMax - 1'b1;
              end else begin
                pos_d = pos_q + 1'b1;
              end
            end else if (pos_q == '0) begin
              dir_up_d = 1'b1;
              pos_d    = PosW'(1);
            end else begin
              pos_d = pos_q - 1'b1;
            end
            pat_d = BarMask << pos_d;
          end
          ModeRotate: pat_d = {pat_q[0], pat_q[NUM_LEDS-1:1]};
          ModeFill: begin
            if (level_q > LvlMax) begin
              level_d    = '0;
              level_up_d = 1'b1;
            end else if (level_up_q) begin
              if (level_q == LvlMax) begin
                level_up_d = 1'b0;
                level_d    = LvlMax - 1'b1;
              end else begin
                level_d = level_q + 1'b1;
              end
            end else if (level_q == '0) begin
              level_up_d = 1'b1;
              level_d    = LvlW'(1);
            end else begin
              level_d = level_q - 1'b1;
            end
            pat_d = thermo(level_d);
          end
          ModeBlink: begin
            blink_d = ~blink_q;
            pat_d   = {NUM_LEDS{blink_d}};
          end
        endcase
      end
    end
    // Dimming masks lit bits before polarity so unlit LEDs stay dark.
    data_d = (pat_d & dim_mask) ^ Pol;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_q     <= '0;
      active_mode_q <= ModeSwing;
      pos_q         <= PosMax;
      dir_up_q      <= 1'b0;
      level_q       <= '0;
      level_up_q    <= 1'b1;
      blink_q       <= 1'b1;
      pat_q         <= BarInit;
      step_q        <= 1'b0;
      data_q        <= BarInit ^ Pol;
    end else begin
      counter_q     <= counter_d;
      active_mode_q <= active_mode_d;
      pos_q         <= pos_d;
      dir_up_q      <= dir_up_d;
      level_q       <= level_d;
      level_up_q    <= level_up_d;
      blink_q       <= blink_d;
      pat_q         <= pat_d;
      step_q        <= step_d;
      data_q        <= data_d;
    end
  end

  assign step = step_q;
  assign data = data_q;

endmodule

// File: tb/tb_leds_pattern_gen.sv
// Randomised scoreboard bench for leds_pattern_gen (N=4, B=2, 8-bit prescaler).
// A second instance with ACTIVE_LOW=1 shares all stimulus and must show the inverted pattern.
module tb_leds_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] mode;
  logic [7:0] period;
  logic       step, step_al;
  logic [3:0] data, data_al;
`ifdef LEDS_PWM_DIM_EN
  logic [3:0] dim = 4'hF;
`endif

  always #5 clk = ~clk;

  leds_pattern_gen #(.NUM_LEDS(4), .BAR_WIDTH(2), .COUNTER_WIDTH(8), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .period(period),
`ifdef LEDS_PWM_DIM_EN
    .dim(dim),
`endif
    .step(step), .data(data)
  );

  leds_pattern_gen #(.NUM_LEDS(4), .BAR_WIDTH(2), .COUNTER_WIDTH(8), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .period(period),
`ifdef LEDS_PWM_DIM_EN
    .dim(dim),
`endif
    .step(step_al), .data(data_al)
  );

  typedef struct packed {
    logic [3:0] data;
    logic       step;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Each mode's repeating display sequence, starting from its init pattern.
  logic [3:0] seq_tab [4][8] = '{
    '{4'b1100, 4'b0110, 4'b0011, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
    '{4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000},
    '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0111, 4'b0011, 4'b0001},
    '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000}
  };
  int seq_len [4] = '{4, 4, 8, 2};

  int m_mode = 0;
  int m_cnt  = 0;
  int m_idx  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  // Reference: each tick advances one position through the mode's sequence.
  function automatic void model_step();
    exp_t e;
    e.step = 1'b0;
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_idx = 0;
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_cnt = 0; m_idx = 0;
    end else if (enable) begin
      if (m_cnt >= int'(period)) begin
        m_cnt  = 0;
        m_idx  = (m_idx + 1) % seq_len[m_mode];
        e.step = 1'b1;
      end else begin
        m_cnt++;
      end
    end
    e.data = seq_tab[m_mode][m_idx];
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("data", 32'(data), 32'(e.data));
      check("step", 32'(step), 32'(e.step));
      check("data_active_low", 32'(data_al), 32'(e.data ^ 4'hF));
      check("step_active_low", 32'(step_al), 32'(e.step));
    end
  end

  task automatic cycle(input logic en, input logic [1:0] md, input logic [7:0] per);
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    enable = en;
    mode   = md;
    period = per;
    @(posedge clk);
    model_step();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_data", 32'(data), 32'h0000000c);
    check("async_reset_step", 32'(step), 32'h0);
    check("async_reset_data_al", 32'(data_al), 32'h00000003);
    @(posedge clk);
    model_step();
  endtask

  initial begin
    logic [1:0] md;
    logic [7:0] per;
    int         len;
    rst_n  = 1'b0;
    enable = 1'b1;
    mode   = 2'd0;
    period = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", 32'(data), 32'h0000000c);
    check("reset_step", 32'(step), 32'h0);
    check("reset_data_al", 32'(data_al), 32'h00000003);

    // Swing at full speed, then a mid-run async reset.
    repeat (8) cycle(1'b1, 2'd0, 8'd0);
    pulse_reset();
    repeat (6) cycle(1'b1, 2'd0, 8'd0);

    // Long period lowered below the running count.
    repeat (150) cycle(1'b1, 2'd0, 8'd200);
    repeat (105) cycle(1'b1, 2'd0, 8'd100);
    repeat (100) cycle(1'b1, 2'd0, 8'd100);
    cycle(1'b1, 2'd2, 8'd100);

    // Blink with a freeze window.
    repeat (6) cycle(1'b1, 2'd3, 8'd3);
    repeat (10) cycle(1'b0, 2'd3, 8'd3);
    repeat (10) cycle(1'b1, 2'd3, 8'd3);

    for (int seg = 0; seg < 150; seg++) begin
      if ($urandom_range(39) == 0) pulse_reset();
      md  = 2'($urandom_range(3));
      per = ($urandom_range(7) == 0) ? 8'($urandom_range(40, 10)) : 8'($urandom_range(3));
      len = $urandom_range(30, 4);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(15) == 0) per = 8'($urandom_range(2));
        cycle(($urandom_range(7) != 0), md, per);
      end
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
